// File: rtl/iccm_boot_ctrl.sv
// UART boot loader: assembles little-endian words from a byte stream, writes
// a word-count-prefixed image into ICCM, and holds the core in reset until done.
module iccm_boot_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              reload_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_no,
    output logic              done_o,
    output logic              err_o
);

    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         buf_q, buf_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0] word;
    logic        active, rx_take, grant, word_done, timeout;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        idle_d     = idle_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        word      = {rx_byte_i, buf_q};
        active    = (state_q == HDR) || (state_q == DATA);
        rx_take   = rx_valid_i && active;
        grant     = req_q && mem_gnt_i;
        word_done = rx_take && (byte_cnt_q == 2'd3);
        // A byte arriving on the deadline cycle still counts as in time.
        timeout   = active && (byte_cnt_q != 2'd0) && !rx_valid_i && (idle_q == IDLE_MAX);

        if (rx_valid_i) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        if (rx_take) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    buf_d[7:0]   = rx_byte_i;
                2'd1:    buf_d[15:8]  = rx_byte_i;
                2'd2:    buf_d[23:16] = rx_byte_i;
                default: buf_d        = buf_q;
            endcase
        end

        case (state_q)
            HDR: begin
                if (timeout) begin
                    state_d = ERR;
                end else if (word_done) begin
                    if (word == 32'd0 || {1'b0, word} > (33'd1 << ADDR_W)) begin
                        state_d = ERR;
                    end else begin
                        rem_d   = word[ADDR_W:0];
                        ptr_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (timeout || (word_done && req_q && !mem_gnt_i)) begin
                    state_d = ERR;
                    req_d   = 1'b0;
                end else begin
                    if (grant) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        rem_d = rem_q - (ADDR_W+1)'(1);
                    end
                    if (grant && rem_q == (ADDR_W+1)'(1)) begin
                        state_d = DONE;
                        req_d   = 1'b0;
                    end else if (word_done) begin
                        // A grant in this cycle means the new word goes one slot further.
                        addr_d  = grant ? ptr_q + ADDR_W'(1) : ptr_q;
                        wdata_d = word;
                        req_d   = 1'b1;
                    end else if (grant) begin
                        req_d = 1'b0;
                    end
                end
            end
            default: req_d = 1'b0;
        endcase

        if (reload_i) begin
            state_d    = HDR;
            byte_cnt_d = '0;
            idle_d     = '0;
            ptr_d      = '0;
            rem_d      = '0;
            req_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HDR;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            idle_q     <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            idle_q     <= idle_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign core_rst_no = (state_q == DONE);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);

endmodule

// File: tb/tb_iccm_boot_ctrl.sv
// Directed bench for iccm_boot_ctrl: expected ICCM writes are queued by the
// stimulus thread and matched by a monitor on every granted request.
module tb_iccm_boot_ctrl;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              reload = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              mem_req;
    logic              mem_gnt = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              err;

    iccm_boot_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .reload_i   (reload),
        .rx_valid_i (rx_valid),
        .rx_byte_i  (rx_byte),
        .mem_req_o  (mem_req),
        .mem_gnt_i  (mem_gnt),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .core_rst_no(core_rst_n),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total  = 0;
    int  passed = 0;

    // Monitor: every accepted write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_gnt) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr=0x%0h data=0x%08h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (32'(mem_addr) == mon_e.addr && mem_wdata == mon_e.data)
                    passed++;
                else
                    $display("FAIL write: got addr=0x%0h data=0x%08h, required addr=0x%0h data=0x%08h",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    endtask

    task automatic reload_pulse();
        reload = 1'b1;
        step(1);
        reload = 1'b0;
    endtask

    task automatic expect_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 32'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_err"}, {31'd0, err}, {31'd0, e});
        check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, c});
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_req", {31'd0, mem_req}, 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Basic two-word image, grant tied high
        mem_gnt = 1'b1;
        expect_wr(0, 32'h0000_0513);
        expect_wr(1, 32'h0010_0593);
        send_word(32'h0000_0002);
        check("load_core_held", {31'd0, core_rst_n}, 0);
        send_word(32'h0000_0513);
        send_word(32'h0010_0593);
        step(3);
        check("load_req_idle", {31'd0, mem_req}, 0);
        check_status("load", 1'b1, 1'b0, 1'b1);

        // Zero word count
        reload_pulse();
        check_status("reload", 1'b0, 1'b0, 1'b0);
        send_word(32'h0000_0000);
        step(2);
        check("hdr0_req", {31'd0, mem_req}, 0);
        check_status("hdr0", 1'b0, 1'b1, 1'b0);

        // Word count one above the ICCM size
        reload_pulse();
        check("reload_err_clr", {31'd0, err}, 0);
        send_word(32'h0000_0011);
        step(2);
        check_status("hdr17", 1'b0, 1'b1, 1'b0);

        // Overrun: second word completes while the first is still ungranted
        reload_pulse();
        mem_gnt = 1'b0;
        send_word(32'h0000_0002);
        send_word(32'h4433_2211);
        step(2);
        check("ovr_req_hold", {31'd0, mem_req}, 1);
        check("ovr_addr_hold", 32'(mem_addr), 0);
        check("ovr_wdata_hold", mem_wdata, 32'h4433_2211);
        send_word(32'h8877_6655);
        check("ovr_req_drop", {31'd0, mem_req}, 0);
        check_status("ovr", 1'b0, 1'b1, 1'b0);

        // Inter-byte timeout, then reload (with a coincident byte to discard) and reload cleanly
        mem_gnt = 1'b1;
        reload_pulse();
        send_word(32'h0000_0001);
        send(8'hAA);
        send(8'hBB);
        step(15);
        check("tmo_early", {31'd0, err}, 0);
        step(6);
        check_status("tmo", 1'b0, 1'b1, 1'b0);
        rx_valid = 1'b1;
        rx_byte  = 8'h07;
        reload_pulse();
        rx_valid = 1'b0;
        expect_wr(0, 32'hEFBE_ADDE);
        send_word(32'h0000_0001);
        send_word(32'hEFBE_ADDE);
        step(3);
        check_status("tmo_reload", 1'b1, 1'b0, 1'b1);

        // Grant of word 0 coincides with completion of word 1
        reload_pulse();
        mem_gnt = 1'b0;
        expect_wr(0, 32'h0403_0201);
        expect_wr(1, 32'h1413_1211);
        expect_wr(2, 32'h2423_2221);
        send_word(32'h0000_0003);
        send_word(32'h0403_0201);
        send(8'h11);
        send(8'h12);
        send(8'h13);
        mem_gnt = 1'b1;
        send(8'h14);
        mem_gnt = 1'b0;
        check("b2b_req", {31'd0, mem_req}, 1);
        check("b2b_addr", 32'(mem_addr), 1);
        check("b2b_wdata", mem_wdata, 32'h1413_1211);
        check("b2b_err", {31'd0, err}, 0);
        mem_gnt = 1'b1;
        send_word(32'h2423_2221);
        step(3);
        check_status("b2b", 1'b1, 1'b0, 1'b1);

        // Full-size image: all 2**ADDR_W addresses, no wrap write
        reload_pulse();
        send_word(32'h0000_0010);
        for (int i = 0; i < 16; i++) begin
            expect_wr(i, 32'(i) * 32'h0101_0101);
            send_word(32'(i) * 32'h0101_0101);
        end
        step(3);
        check_status("full", 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-load, then fresh load from address 0
        reload_pulse();
        send_word(32'h0000_0002);
        send(8'h55);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check_status("mid_rst", 1'b0, 1'b0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(1);
        expect_wr(0, 32'h1234_5678);
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        step(3);
        check_status("post_rst", 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iccm_boot_ctrl.md
ICCM_BOOT_CTRL -- requirements
Module: iccm_boot_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: ICCM word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 100000: max idle cycles between bytes of one word.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port reload_i  input  1  synchronous pulse; restart the load sequence.
REQ-006 SHALL have port rx_valid_i  input  1  one-cycle strobe; UART receiver has a byte. No backpressure.
REQ-007 SHALL have port rx_byte_i  input  8  received byte, valid with rx_valid_i.
REQ-008 SHALL have port mem_req_o  output  1  ICCM write request.
REQ-009 SHALL have port mem_gnt_i  input  1  ICCM grant; write done when mem_req_o & mem_gnt_i.
REQ-010 SHALL have port mem_addr_o  output  ADDR_W  ICCM word address.
REQ-011 SHALL have port mem_wdata_o  output  32  ICCM write data.
REQ-012 SHALL have port core_rst_no  output  1  core reset, active-low; released only after a complete load.
REQ-013 SHALL have port done_o  output  1  load complete.
REQ-014 SHALL have port err_o  output  1  load aborted; sticky until reload_i or reset.

Function
REQ-015 SHALL assemble bytes little-endian: byte k of a word (k=0..3) goes to bits [8k+7:8k]; byte counter wraps 3->0.
REQ-016 SHALL implement states HDR, DATA, DONE, ERR.
REQ-017 HDR: the first complete word is the word count N; N==0 or N>2**ADDR_W -> ERR; otherwise store N, clear write pointer to 0, -> DATA.
REQ-018 DATA: each complete word is latched into mem_wdata_o with mem_addr_o=write pointer, and mem_req_o is set on the next cycle (one cycle after the 4th byte strobe).
REQ-019 mem_req_o, mem_addr_o and mem_wdata_o SHALL stay stable while mem_req_o=1 and mem_gnt_i=0.
REQ-020 On a grant cycle: write pointer +1, remaining count -1, and mem_req_o clears next cycle unless a new word completes in that same cycle, in which case mem_req_o stays 1 with the new address/data.
REQ-021 If a word completes while a request is pending and ungranted in that cycle (overrun) -> ERR.
REQ-022 When the remaining count reaches 0 on a grant -> DONE the next cycle.
REQ-023 DONE: core_rst_no=1, done_o=1, mem_req_o=0; rx bytes ignored.
REQ-024 Idle counter SHALL clear on every rx_valid_i and saturate; if byte counter !=0 and idle counter reaches TIMEOUT-1 -> ERR.
REQ-025 ERR: err_o=1, core_rst_no=0, mem_req_o dropped immediately (pending write abandoned), rx bytes ignored.
REQ-026 In HDR, DATA and ERR, core_rst_no SHALL be 0.
REQ-027 reload_i in any state SHALL: -> HDR, clear byte counter, idle counter, pointer, remaining count, err_o, done_o, mem_req_o, and drive core_rst_no=0 the next cycle.
REQ-028 reload_i coincident with rx_valid_i SHALL take priority; that byte is discarded.
REQ-029 Write pointer SHALL be ADDR_W bits; N=2**ADDR_W writes addresses 0..2**ADDR_W-1 with no wrap write.

Reset
REQ-030 On rst_ni=0: state HDR, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_no=0, done_o=0, err_o=0, all counters 0.
REQ-031 Reset deasserted mid-load SHALL discard all progress; the load restarts at HDR.

Verification
REQ-032 Bytes 02 00 00 00, 13 05 00 00, 93 05 10 00, gnt tied 1 -> writes (0,0x00000513),(1,0x00100593); done_o=1, core_rst_no=1.
REQ-033 Header 00 00 00 00 -> err_o=1, no mem_req_o, core_rst_no=0.
REQ-034 N=2, mem_gnt_i held 0 while second word's 4 bytes arrive -> err_o=1 on overrun, mem_req_o=0.
REQ-035 N=1, 2 data bytes then TIMEOUT idle cycles -> err_o=1; then reload_i and a valid 8-byte stream -> done_o=1, err_o=0.
REQ-036 N=3, grant of word 1 coincides with 4th byte of word 2 -> mem_req_o stays 1, addresses 0,1,2 written in order, no error.
REQ-037 rst_ni pulsed low after 5 bytes -> all outputs at reset values; fresh stream loads correctly from address 0.
